ad_chan_avg: RTL and testbench
==============================

# ad_chan_avg

Downstream consumer of the 4-channel SPI ADC controller. Detects each completed SPI frame from the controller's chip select, discards configuration and pipeline-fill frames, tags each 16-bit result with channel 0 or 1, and accumulates 2^AVG_LOG2 results per channel. Each finished per-channel average is presented on a valid/ready port toward the stability-processing logic.

## Interface
- AVG_LOG2, 4: log2 of samples averaged per channel (1..8).
- SKIP_FRAMES, 8: frames discarded after reset (7 configuration frames + 1 pipeline frame).
- FIRST_CH, 1: channel tag of the first non-discarded frame.
- clk  in  1  system clock, same clock as the SPI controller.
- RESET  in  1  asynchronous, active-high reset.
- ad_cs  in  1  controller chip select; rising edge marks frame complete.
- ad_data  in  16  controller receive word; stable and complete on the cycle ad_cs is first sampled high.
- avg_ready  in  1  downstream accepts the average.
- avg_valid  out  1  average available.
- avg_ch  out  1  channel of avg_data.
- avg_data  out  16  truncated mean.
- avg_min, avg_max  out  16 each  window extremes (AD_AVG_MINMAX_EN only).
- ovf  out  1  sticky: a finished average was dropped.
- frame_cnt  out  16  total frames seen since reset; saturates at 16'hFFFF.

## Operation
- Edge detect: one register cs_d. Frame event fe = ad_cs & ~cs_d. cs_d resets to 1, so no event occurs at reset release.
- States:
  - SKIP: count fe up to SKIP_FRAMES. Then go to RUN with ch_tag = FIRST_CH.
  - RUN: on each fe, latch {ch_tag, ad_data} into sample register s_valid/s_ch/s_data. Toggle ch_tag.
- Accumulate stage: on s_valid, add s_data into the accumulator for s_ch. The accumulator is 16+AVG_LOG2 bits, unsigned, and cannot overflow. Also increment that channel's count, which is AVG_LOG2 bits wide.
- Window end: when the count wraps to 0:
  - result = acc >> AVG_LOG2.
  - The accumulator restarts with the current sample's contribution already cleared; the next sample starts a fresh window.
- Output register:
  - If avg_valid == 0, load the result and set avg_valid.
  - If avg_valid == 1 and the register is not being popped this cycle, drop the result and set ovf.
  - A pop (avg_valid & avg_ready) on the same cycle as a window end loads the new result. avg_valid stays 1 and ovf is not set.
- Both channels finishing on the same cycle is impossible, because samples arrive at most once per frame.
- Reset values: all outputs 0; state SKIP; accumulators, counts and frame_cnt 0; cs_d 1.
- Reset mid-window discards partial sums and re-runs SKIP. RESET is the only clear for ovf.

## Timing
- Cycle E: ad_cs sampled high for the first time.
- E+1: sample register valid.
- E+2: avg_valid high, for a window-ending sample.
- Latency from frame edge to avg_valid is 2 clocks.
- avg_data, avg_ch, avg_min and avg_max hold stable while avg_valid & ~avg_ready.
- avg_valid falls the cycle after acceptance, unless reloaded on that same cycle.
- Frames are at least 34 clocks apart, so only one sample is in flight per stage.

## Configuration
- AD_AVG_MINMAX_EN defined:
  - Per-channel min/max registers track each window.
  - They are reloaded from the first sample of each window.
  - avg_min and avg_max load together with avg_data.
- Not defined: no min/max registers, and avg_min and avg_max are tied to 0.

## Structure
- Package ad_pkg:
  - AD_WORD_W = 16.
  - Channel typedef ad_ch_t (CH0, CH1).
  - State typedef {SKIP, RUN}.
  - Default SKIP_FRAMES.
- Sub-module ad_chan_acc, one instance per channel, holds:
  - the accumulator and count;
  - min/max when AD_AVG_MINMAX_EN is defined.
  - Inputs: clk, RESET, s_valid, s_data. Outputs: done, mean, min, max.
- Top level holds the edge detect, the SKIP/RUN FSM, the channel tag, the output register and ovf.

## Test plan
- Reset then 8 frames: no sample accepted; frame_cnt = 8; avg_valid stays 0.
- AVG_LOG2 = 2 with alternating ch1/ch0 words: ch1 words 100, 200, 300, 401 and ch0 words 10 (×4) give avg_ch = 1, avg_data = 250, then avg_ch = 0, avg_data = 10.
- avg_ready held 0 across two window ends: first result held, ovf = 1, second result absent.
- Pop on the same cycle as a window end: avg_valid stays 1, new value appears next cycle, ovf = 0.
- RESET asserted mid-window after 3 samples: outputs 0, and the next average requires 8 skip frames plus 4 fresh samples.
- AD_AVG_MINMAX_EN with ch0 words 5, 900, 17, 40: avg_min = 5, avg_max = 900, avg_data = 240.

Source files
------------

// File: rtl/ad_pkg.sv
// Shared types and constants for the ADC channel averager.
// Optional feature macro used by this slice: AD_AVG_MINMAX_EN.
package ad_pkg;

   localparam int unsigned AD_WORD_W      = 16;
   localparam int unsigned AD_SKIP_FRAMES = 8;

   typedef enum logic {
      CH0 = 1'b0,
      CH1 = 1'b1
   } ad_ch_t;

   typedef logic [0:0] ad_state_t;
   localparam ad_state_t SKIP = 1'b0;
   localparam ad_state_t RUN  = 1'b1;

endpackage

// File: rtl/ad_chan_avg_if.sv
// Valid/ready average port toward the stability-processing logic.
// avg_min/avg_max carry data only when AD_AVG_MINMAX_EN is defined.
interface ad_chan_avg_if;
   import ad_pkg::*;

   logic                 avg_valid;
   logic                 avg_ready;
   ad_ch_t               avg_ch;
   logic [AD_WORD_W-1:0] avg_data;
   logic [AD_WORD_W-1:0] avg_min;
   logic [AD_WORD_W-1:0] avg_max;

   modport master (
      output avg_valid, avg_ch, avg_data, avg_min, avg_max,
      input  avg_ready
   );

   modport slave (
      input  avg_valid, avg_ch, avg_data, avg_min, avg_max,
      output avg_ready
   );

endinterface

// File: rtl/ad_chan_avg_acc.sv
// Per-channel window accumulator: sums 2^AVG_LOG2 samples and flags the
// window-ending sample combinationally so the top can register the result.
// Window min/max tracking is built only when AD_AVG_MINMAX_EN is defined.
module ad_chan_acc
   import ad_pkg::*;
#(
   parameter int unsigned AVG_LOG2 = 4
) (
   input  logic                 clk,
   input  logic                 RESET,
   input  logic                 s_valid,
   input  logic [AD_WORD_W-1:0] s_data,
   output logic                 done,
   output logic [AD_WORD_W-1:0] mean,
   output logic [AD_WORD_W-1:0] min,
   output logic [AD_WORD_W-1:0] max
);

   localparam int unsigned ACC_W = AD_WORD_W + AVG_LOG2;

   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    sum;
   logic [AVG_LOG2-1:0] cnt;

   // Sum including the current sample; done marks the last sample of a window.
   always_comb begin
      sum  = acc + ACC_W'(s_data);
      done = s_valid & (cnt == '1);
      mean = AD_WORD_W'(sum >> AVG_LOG2);
   end

   // Accumulate, restarting from zero once the window-ending sample is consumed.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         acc <= '0;
         cnt <= '0;
      end else if (s_valid) begin
         acc <= done ? '0 : sum;
         cnt <= cnt + AVG_LOG2'(1);
      end
   end

`ifdef AD_AVG_MINMAX_EN
   logic [AD_WORD_W-1:0] min_r;
   logic [AD_WORD_W-1:0] max_r;

   // Running extremes including the current sample; first sample reseeds them.
   always_comb begin
      min = s_data;
      max = s_data;
      if (cnt != '0) begin
         if (min_r < s_data) min = min_r;
         if (max_r > s_data) max = max_r;
      end
   end

   // Hold the window extremes between samples.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         min_r <= '0;
         max_r <= '0;
      end else if (s_valid) begin
         min_r <= min;
         max_r <= max;
      end
   end
`else
   // No extremes tracked in this build.
   always_comb begin
      min = '0;
      max = '0;
   end
`endif

endmodule

// File: rtl/ad_chan_avg.sv
// Two-channel averager behind the SPI ADC controller: frame edge detect,
// SKIP/RUN frame filter, channel tagging, and the average output register.
// Define AD_AVG_MINMAX_EN to report per-window min/max alongside the mean.
module ad_chan_avg
   import ad_pkg::*;
#(
   parameter int unsigned AVG_LOG2    = 4,
   parameter int unsigned SKIP_FRAMES = AD_SKIP_FRAMES,
   parameter int unsigned FIRST_CH    = 1
) (
   input  logic                 clk,
   input  logic                 RESET,
   input  logic                 ad_cs,
   input  logic [AD_WORD_W-1:0] ad_data,
   ad_chan_avg_if.master        avg,
   output logic                 ovf,
   output logic [AD_WORD_W-1:0] frame_cnt
);

   logic                 cs_d;
   logic                 fe;
   ad_state_t            state;
   ad_ch_t               ch_tag;
   logic                 s_valid;
   ad_ch_t               s_ch;
   logic [AD_WORD_W-1:0] s_data;

   logic                 done0, done1;
   logic [AD_WORD_W-1:0] mean0, mean1, min0, min1, max0, max1;

   logic                 res_done;
   ad_ch_t               res_ch;
   logic [AD_WORD_W-1:0] res_mean, res_min, res_max;
   logic                 pop;

   assign fe = ad_cs & ~cs_d;

   // Chip-select history; starts high so reset release is not a frame edge.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) cs_d <= 1'b1;
      else       cs_d <= ad_cs;
   end

   // Saturating count of every frame seen since reset.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET)                      frame_cnt <= '0;
      else if (fe && frame_cnt != '1) frame_cnt <= frame_cnt + AD_WORD_W'(1);
   end

   // Discard the configuration/pipeline frames, then alternate channel tags.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state  <= SKIP;
         ch_tag <= CH0;
      end else if (state == SKIP) begin
         if (frame_cnt >= AD_WORD_W'(SKIP_FRAMES)) begin
            state  <= RUN;
            ch_tag <= ad_ch_t'(FIRST_CH != 0);
         end
      end else if (fe) begin
         ch_tag <= (ch_tag == CH0) ? CH1 : CH0;
      end
   end

   // Sample register: one tagged result per accepted frame.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         s_valid <= 1'b0;
         s_ch    <= CH0;
         s_data  <= '0;
      end else begin
         s_valid <= fe && (state == RUN);
         if (fe) begin
            s_ch   <= ch_tag;
            s_data <= ad_data;
         end
      end
   end

   ad_chan_acc #(.AVG_LOG2(AVG_LOG2)) u_acc0 (
      .clk     (clk),
      .RESET   (RESET),
      .s_valid (s_valid && (s_ch == CH0)),
      .s_data  (s_data),
      .done    (done0),
      .mean    (mean0),
      .min     (min0),
      .max     (max0)
   );

   ad_chan_acc #(.AVG_LOG2(AVG_LOG2)) u_acc1 (
      .clk     (clk),
      .RESET   (RESET),
      .s_valid (s_valid && (s_ch == CH1)),
      .s_data  (s_data),
      .done    (done1),
      .mean    (mean1),
      .min     (min1),
      .max     (max1)
   );

   // Select the finishing channel; both cannot finish on the same cycle.
   always_comb begin
      res_done = done0 | done1;
      res_ch   = done1 ? CH1 : CH0;
      res_mean = done1 ? mean1 : mean0;
      res_min  = done1 ? min1  : min0;
      res_max  = done1 ? max1  : max0;
      pop      = avg.avg_valid & avg.avg_ready;
   end

   // Output register: load when empty or being popped, otherwise drop and flag.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         avg.avg_valid <= 1'b0;
         avg.avg_ch    <= CH0;
         avg.avg_data  <= '0;
         avg.avg_min   <= '0;
         avg.avg_max   <= '0;
         ovf           <= 1'b0;
      end else if (res_done) begin
         if (!avg.avg_valid || pop) begin
            avg.avg_valid <= 1'b1;
            avg.avg_ch    <= res_ch;
            avg.avg_data  <= res_mean;
            avg.avg_min   <= res_min;
            avg.avg_max   <= res_max;
         end else begin
            ovf <= 1'b1;
         end
      end else if (pop) begin
         avg.avg_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ad_chan_avg.sv
// Directed bench for ad_chan_avg with AVG_LOG2 = 2 (4-sample windows).
// Min/max expectations follow AD_AVG_MINMAX_EN.
module tb_ad_chan_avg;

   logic        clk = 1'b0;
   logic        RESET;
   logic        ad_cs;
   logic [15:0] ad_data;
   logic        ovf;
   logic [15:0] frame_cnt;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   ad_chan_avg_if avg_if ();

   ad_chan_avg #(
      .AVG_LOG2    (2),
      .SKIP_FRAMES (8),
      .FIRST_CH    (1)
   ) dut (
      .clk       (clk),
      .RESET     (RESET),
      .ad_cs     (ad_cs),
      .ad_data   (ad_data),
      .avg       (avg_if.master),
      .ovf       (ovf),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Low for 4 cycles, then present the word and raise chip select.
   task automatic frame_rise(input logic [15:0] d);
      @(negedge clk);
      ad_cs = 1'b0;
      repeat (4) @(negedge clk);
      ad_data = d;
      ad_cs   = 1'b1;
   endtask

   task automatic frame_hold();
      repeat (29) @(negedge clk);
   endtask

   task automatic send_frame(input logic [15:0] d);
      frame_rise(d);
      frame_hold();
   endtask

   task automatic pop_and_check(input string tag);
      @(negedge clk);
      avg_if.avg_ready = 1'b1;
      @(posedge clk);
      #1;
      chk(tag, 32'(avg_if.avg_valid), 0);
      @(negedge clk);
      avg_if.avg_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      RESET = 1'b1;
      ad_cs = 1'b0;
      #1;
      chk("rst_valid", 32'(avg_if.avg_valid), 0);
      chk("rst_ovf",   32'(ovf), 0);
      chk("rst_fcnt",  32'(frame_cnt), 0);
      chk("rst_data",  32'(avg_if.avg_data), 0);
      chk("rst_ch",    32'(avg_if.avg_ch), 0);
      repeat (3) @(negedge clk);
      RESET = 1'b0;
   endtask

   task automatic skip_frames();
      for (int i = 0; i < 8; i++) send_frame(16'd999);
      chk("skip_fcnt",  32'(frame_cnt), 8);
      chk("skip_valid", 32'(avg_if.avg_valid), 0);
   endtask

   initial begin
      RESET            = 1'b1;
      ad_cs            = 1'b0;
      ad_data          = '0;
      avg_if.avg_ready = 1'b0;
      do_reset();
      skip_frames();

      // Window 1: ch1 100,200,300,401 -> 250; ch0 10 x4 -> 10.
      send_frame(16'd100); send_frame(16'd10);
      send_frame(16'd200); send_frame(16'd10);
      send_frame(16'd300); send_frame(16'd10);
      frame_rise(16'd401);
      @(posedge clk); #1;
      chk("lat_e0", 32'(avg_if.avg_valid), 0);
      @(posedge clk); #1;
      chk("lat_e2", 32'(avg_if.avg_valid), 1);
      frame_hold();
      chk("w1_ch1_ch",   32'(avg_if.avg_ch), 1);
      chk("w1_ch1_data", 32'(avg_if.avg_data), 250);
      chk("w1_ovf",      32'(ovf), 0);
      pop_and_check("w1_pop1");
      send_frame(16'd10);
      chk("w1_ch0_valid", 32'(avg_if.avg_valid), 1);
      chk("w1_ch0_ch",    32'(avg_if.avg_ch), 0);
      chk("w1_ch0_data",  32'(avg_if.avg_data), 10);
      pop_and_check("w1_pop0");

      // Window 2: ch1 20,20,20,24 -> 21; ch0 5,900,17,40 -> 240, popped on collision.
      send_frame(16'd20); send_frame(16'd5);
      send_frame(16'd20); send_frame(16'd900);
      send_frame(16'd20); send_frame(16'd17);
      send_frame(16'd24);
      chk("w2_ch1_data", 32'(avg_if.avg_data), 21);
`ifdef AD_AVG_MINMAX_EN
      chk("w2_ch1_min", 32'(avg_if.avg_min), 20);
      chk("w2_ch1_max", 32'(avg_if.avg_max), 24);
`else
      chk("w2_ch1_min", 32'(avg_if.avg_min), 0);
      chk("w2_ch1_max", 32'(avg_if.avg_max), 0);
`endif
      frame_rise(16'd40);
      @(posedge clk);
      @(negedge clk);
      avg_if.avg_ready = 1'b1;
      @(posedge clk); #1;
      chk("col_valid", 32'(avg_if.avg_valid), 1);
      chk("col_ch",    32'(avg_if.avg_ch), 0);
      chk("col_data",  32'(avg_if.avg_data), 240);
      chk("col_ovf",   32'(ovf), 0);
`ifdef AD_AVG_MINMAX_EN
      chk("col_min", 32'(avg_if.avg_min), 5);
      chk("col_max", 32'(avg_if.avg_max), 900);
`else
      chk("col_min", 32'(avg_if.avg_min), 0);
      chk("col_max", 32'(avg_if.avg_max), 0);
`endif
      @(negedge clk);
      avg_if.avg_ready = 1'b0;
      frame_hold();
      chk("col_hold", 32'(avg_if.avg_data), 240);
      pop_and_check("col_pop");

      // Window 3: ready low across both window ends; ch1 -> 2 held, ch0 dropped.
      send_frame(16'd1); send_frame(16'd8);
      send_frame(16'd2); send_frame(16'd8);
      send_frame(16'd3); send_frame(16'd8);
      send_frame(16'd4);
      chk("ovf_first_data", 32'(avg_if.avg_data), 2);
      chk("ovf_pre",        32'(ovf), 0);
      send_frame(16'd8);
      chk("ovf_set",        32'(ovf), 1);
      chk("ovf_held_ch",    32'(avg_if.avg_ch), 1);
      chk("ovf_held_data",  32'(avg_if.avg_data), 2);
      pop_and_check("ovf_second_absent");
      chk("ovf_sticky",     32'(ovf), 1);

      // Reset mid-window after 3 samples; partial sums must not survive.
      send_frame(16'd5); send_frame(16'd6); send_frame(16'd7);
      do_reset();
      skip_frames();
      send_frame(16'd60); send_frame(16'd1);
      send_frame(16'd60); send_frame(16'd1);
      send_frame(16'd60); send_frame(16'd1);
      chk("rs_early_valid", 32'(avg_if.avg_valid), 0);
      send_frame(16'd64);
      chk("rs_valid", 32'(avg_if.avg_valid), 1);
      chk("rs_ch",    32'(avg_if.avg_ch), 1);
      chk("rs_data",  32'(avg_if.avg_data), 61);
      chk("rs_fcnt",  32'(frame_cnt), 15);
      chk("rs_ovf",   32'(ovf), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
